// File: rtl/lbdr_dr_pkt.sv
// lbdr_dr_pkt - per-input-port LBDR routing unit for a 2D mesh NoC.
//   Minimal LBDR routing with a one-hop deroute fallback, plus packet state:
//   the route is computed on HEADER, held through BODY (and bubbles) and
//   released on the edge after TAIL.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_Rxy[7:0]                {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, captured in reset
//   cfg_Cx[3:0]                 {Cs,Cw,Ce,Cn}, captured in reset
//   cfg_dr[7:0]                 deroute port per primary dir {S,W,E,N}, 0=N 1=E 2=W 3=S
//   cfg_cur_addr[2*CW-1:0]      this router's address {y,x}, captured in reset
//   empty, flit_id, dst_addr    FIFO head
//   Nport..Lport                registered one-hot request
//   derouted                    current packet holds a deroute port
//   route_err                   one-cycle pulse for an unroutable header
//
// state    | meaning
// S_IDLE   | no packet owns a route; only a HEADER is acted on
// S_ACTIVE | route held for the current packet until TAIL or a new HEADER
module lbdr_dr_pkt #(
  parameter int          CW      = 2,
  parameter logic [2:0]  HDR_ID  = 3'b001,
  parameter logic [2:0]  BODY_ID = 3'b010,
  parameter logic [2:0]  TAIL_ID = 3'b100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      cfg_Rxy,
  input  logic [3:0]      cfg_Cx,
  input  logic [7:0]      cfg_dr,
  input  logic [2*CW-1:0] cfg_cur_addr,
  input  logic            empty,
  input  logic [2:0]      flit_id,
  input  logic [2*CW-1:0] dst_addr,
  output logic            Nport,
  output logic            Eport,
  output logic            Wport,
  output logic            Sport,
  output logic            Lport,
  output logic            derouted,
  output logic            route_err
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t          r_state, w_nxt_state;
  logic [7:0]      r_rxy;
  logic [3:0]      r_cx;
  logic [7:0]      r_dr;
  logic [2*CW-1:0] r_cur;
  // Port vectors are indexed by the deroute code: 0=N 1=E 2=W 3=S, 4=L
  logic [4:0]      r_port, w_nxt_port;
  logic            r_derouted, w_nxt_der;
  logic            r_route_err, w_nxt_err;

  logic [CW-1:0]   w_xd, w_yd, w_xc, w_yc;
  logic            w_n1, w_s1, w_e1, w_w1, w_local;
  logic [3:0]      w_min;
  logic [1:0]      w_alt;
  logic [4:0]      w_req;
  logic            w_ok, w_is_dr;
  logic            w_hdr, w_tail, w_body, w_single;

  assign w_xd = dst_addr[CW-1:0];
  assign w_yd = dst_addr[2*CW-1:CW];
  assign w_xc = r_cur[CW-1:0];
  assign w_yc = r_cur[2*CW-1:CW];

  assign w_n1 = w_yd < w_yc;
  assign w_s1 = w_yd > w_yc;
  assign w_e1 = w_xd > w_xc;
  assign w_w1 = w_xd < w_xc;
  assign w_local = ~w_n1 & ~w_s1 & ~w_e1 & ~w_w1;

  // r_rxy: [0]Rne [1]Rnw [2]Ren [3]Res [4]Rwn [5]Rws [6]Rse [7]Rsw
  assign w_min[0] = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & r_rxy[0]) | (w_n1 & w_w1 & r_rxy[1])) & r_cx[0];
  assign w_min[1] = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & r_rxy[2]) | (w_e1 & w_s1 & r_rxy[3])) & r_cx[1];
  assign w_min[2] = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & r_rxy[4]) | (w_w1 & w_s1 & r_rxy[5])) & r_cx[2];
  assign w_min[3] = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & r_rxy[6]) | (w_s1 & w_w1 & r_rxy[7])) & r_cx[3];

  // Primary direction for deroute: N, then S, then E, then W.
  always_comb begin
    if (w_n1)      w_alt = r_dr[1:0];
    else if (w_s1) w_alt = r_dr[7:6];
    else if (w_e1) w_alt = r_dr[3:2];
    else           w_alt = r_dr[5:4];
  end

  always_comb begin
    w_req   = 5'b0;
    w_ok    = 1'b1;
    w_is_dr = 1'b0;
    if (w_local) begin
      w_req[4] = 1'b1;
    end else if (w_min != 4'b0) begin
      // Only one request is issued even if LBDR allows two: N > S > E > W
      if (w_min[0])      w_req[0] = 1'b1;
      else if (w_min[3]) w_req[3] = 1'b1;
      else if (w_min[1]) w_req[1] = 1'b1;
      else               w_req[2] = 1'b1;
    end else if (r_cx[w_alt]) begin
      w_req[w_alt] = 1'b1;
      w_is_dr      = 1'b1;
    end else begin
      w_ok = 1'b0;
    end
  end

  // flit_id is matched per bit so a HEADER|TAIL single-flit packet is both
  assign w_hdr    = ~empty & |(flit_id & HDR_ID);
  assign w_tail   = ~empty & |(flit_id & TAIL_ID);
  assign w_body   = ~empty & |(flit_id & BODY_ID);
  assign w_single = w_hdr & w_tail;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_port  = r_port;
    w_nxt_der   = r_derouted;
    w_nxt_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_port = 5'b0;
        w_nxt_der  = 1'b0;
      end
      S_ACTIVE: begin
        if (w_tail) begin
          w_nxt_port  = 5'b0;
          w_nxt_der   = 1'b0;
          w_nxt_state = S_IDLE;
        end else if (w_body) begin
          w_nxt_port = r_port;
          w_nxt_der  = r_derouted;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // A HEADER always starts a fresh route, also when a TAIL went missing
    if (w_hdr) begin
      w_nxt_port  = 5'b0;
      w_nxt_der   = 1'b0;
      w_nxt_state = S_IDLE;
      if (w_ok) begin
        w_nxt_port = w_req;
        // Single-flit packets are released next cycle from IDLE, so they
        // never report a held deroute
        if (!w_single) begin
          w_nxt_state = S_ACTIVE;
          w_nxt_der   = w_is_dr;
        end
      end else begin
        w_nxt_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxy       <= cfg_Rxy;
      r_cx        <= cfg_Cx;
      r_dr        <= cfg_dr;
      r_cur       <= cfg_cur_addr;
      r_state     <= S_IDLE;
      r_port      <= 5'b0;
      r_derouted  <= 1'b0;
      r_route_err <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_port      <= w_nxt_port;
      r_derouted  <= w_nxt_der;
      r_route_err <= w_nxt_err;
    end
  end

  assign Nport     = r_port[0];
  assign Eport     = r_port[1];
  assign Wport     = r_port[2];
  assign Sport     = r_port[3];
  assign Lport     = r_port[4];
  assign derouted  = r_derouted;
  assign route_err = r_route_err;

endmodule
